// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one frame-buffer RAM between display fetch (priority) and a req/ack writer, with frame tick; define VRAM_VBLANK_ONLY_EN to allow writes only in vertical blanking
module vram_arbiter #(
  parameter int SCALE    = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COLOR_W  = 8,
  parameter int ADDR_W   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         h_idx,
  input  logic [9:0]         v_idx,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  output logic               wr_oob,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_valid,
  output logic               frame_tick
);
  localparam int SH = $clog2(SCALE);
  localparam int FB_W = H_ACTIVE / SCALE;
  localparam int FB_DEPTH = FB_W * (V_ACTIVE / SCALE);
  localparam logic [9:0] PH_MASK = 10'(SCALE - 1);
  logic vis, disp, grant, in_range;
  logic [1:0] vis_d, disp_d;
  logic [ADDR_W-1:0] rd_addr;
  always_comb begin
    vis = h_idx < 10'(H_ACTIVE) && v_idx < 10'(V_ACTIVE);
    disp = vis && (h_idx & PH_MASK) == '0;
    rd_addr = ADDR_W'((32'(v_idx) >> SH) * FB_W + (32'(h_idx) >> SH));
    in_range = 32'(wr_addr) < FB_DEPTH;
`ifdef VRAM_VBLANK_ONLY_EN
    grant = wr_req && !disp && !wr_ack && v_idx >= 10'(V_ACTIVE);
`else
    grant = wr_req && !disp && !wr_ack;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      wr_oob     <= 1'b0;
      vis_d      <= '0;
      disp_d     <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      frame_tick <= 1'b0;
    end else begin
      mem_addr   <= disp ? rd_addr : grant ? wr_addr : mem_addr;
      mem_we     <= grant && in_range;
      mem_wdata  <= grant ? wr_data : mem_wdata;
      wr_ack     <= grant;
      wr_oob     <= wr_oob || (grant && !in_range);
      vis_d      <= {vis_d[0], vis};
      disp_d     <= {disp_d[0], disp};
      pix_valid  <= vis_d[1];
      pix_data   <= !vis_d[1] ? '0 : disp_d[1] ? mem_rdata : pix_data;
      frame_tick <= v_idx == 10'(V_ACTIVE) && h_idx == '0;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter display fetch, write arbitration, out-of-range writes, reset and frame tick
module tb_vram_arbiter;
  typedef struct packed {logic v; logic [7:0] d;} pix_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] h_idx = 10'd700, v_idx = 10'd500;
  logic wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic wr_ack, wr_oob, mem_we, pix_valid, frame_tick;
  logic [14:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, pix_data;
  logic [7:0] ram [32768];
  bit ram_v [32768];
  logic [7:0] shadow [32768];
  pix_t pq[$];
  logic tq[$];
  pix_t exp_pix;
  int compared = 0, mismatched = 0, ticks = 0, t0, acks;
  bit mon_en = 1'b0, nxt;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .h_idx(h_idx), .v_idx(v_idx),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_oob(wr_oob),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // unwritten locations read back as addr[7:0]
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      ram_v[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(int h, int v);
    @(posedge clk);
    #1;
    h_idx = 10'(h);
    v_idx = 10'(v);
    if (h < 640 && v < 480) pq.push_back(pix_t'{1'b1, shadow[(v / 4) * 160 + h / 4]});
    else pq.push_back(pix_t'{1'b0, 8'h00});
    tq.push_back(h == 0 && v == 480);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (pq.size() == 4) begin
      exp_pix = pq.pop_front();
      chk("pix_valid", 32'(pix_valid), 32'(exp_pix.v));
      chk("pix_data", 32'(pix_data), 32'(exp_pix.d));
    end
    if (tq.size() == 2) chk("frame_tick", 32'(frame_tick), 32'(tq.pop_front()));
    if (frame_tick === 1'b1) ticks++;
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    chk({tag, "_wr_oob"}, 32'(wr_oob), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) shadow[i] = 8'(i);
    repeat (3) step(700, 500);
    @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;
    pq.delete();
    tq.delete();
    step(700, 500);
    rst = 1'b0;
    for (int h = 0; h < 660; h++) begin
      step(h, 8);
      if (h == 1) begin
        @(negedge clk);
        chk("disp_mem_addr", 32'(mem_addr), 320);
        chk("disp_mem_we", 32'(mem_we), 0);
      end
    end
`ifndef VRAM_VBLANK_ONLY_EN
    for (int h = 0; h < 660; h++) begin
      step(h, 12);
      if (h == 4) begin
        wr_req = 1'b1;
        wr_addr = 15'd100;
        wr_data = 8'h5A;
      end
      if (h == 7) wr_req = 1'b0;
      if (h == 5 || h == 7) begin
        @(negedge clk);
        chk("slot_no_ack", 32'(wr_ack), 0);
        chk("slot_no_we", 32'(mem_we), 0);
      end
      if (h == 6) begin
        @(negedge clk);
        chk("wr_ack", 32'(wr_ack), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 100);
        chk("wr_wdata", 32'(mem_wdata), 32'h5A);
        shadow[100] = 8'h5A;
      end
    end
`else
    for (int h = 0; h < 16; h++) begin
      step(h, 100);
      if (h == 0) begin
        wr_req = 1'b1;
        wr_addr = 15'd300;
        wr_data = 8'h77;
      end
      @(negedge clk);
      chk("vis_row_no_ack", 32'(wr_ack), 0);
    end
    for (int h = 640; h < 660; h++) begin
      step(h, 300);
      @(negedge clk);
      chk("hblank_no_ack", 32'(wr_ack), 0);
    end
    step(0, 480);
    @(negedge clk);
    chk("vb_pre_ack", 32'(wr_ack), 0);
    step(1, 480);
    @(negedge clk);
    chk("vb_ack", 32'(wr_ack), 1);
    chk("vb_we", 32'(mem_we), 1);
    chk("vb_addr", 32'(mem_addr), 300);
    chk("vb_wdata", 32'(mem_wdata), 32'h77);
    shadow[300] = 8'h77;
    step(2, 480);
    wr_req = 1'b0;
`endif
    acks = 0;
    nxt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(700 + c, 500);
      if (c == 0 || nxt) begin
        wr_req = 1'b1;
        wr_addr = 15'(200 + acks);
        wr_data = 8'(160 + acks);
      end
      nxt = 1'b0;
      @(negedge clk);
      chk("b2b_ack_phase", 32'(wr_ack), 32'(c % 2));
      if (wr_ack) begin
        chk("b2b_we", 32'(mem_we), 1);
        chk("b2b_addr", 32'(mem_addr), 32'(200 + acks));
        chk("b2b_wdata", 32'(mem_wdata), 32'(160 + acks));
        shadow[200 + acks] = 8'(160 + acks);
        acks++;
        nxt = 1'b1;
      end
    end
    step(720, 500);
    wr_req = 1'b0;
    chk("b2b_count", 32'(acks), 10);
    step(730, 500);
    wr_req = 1'b1;
    wr_addr = 15'd19200;
    wr_data = 8'hFF;
    step(731, 500);
    @(negedge clk);
    chk("oob_ack", 32'(wr_ack), 1);
    chk("oob_we", 32'(mem_we), 0);
    chk("oob_flag", 32'(wr_oob), 1);
    step(732, 500);
    wr_req = 1'b0;
    @(negedge clk);
    chk("oob_ack_once", 32'(wr_ack), 0);
    chk("oob_sticky", 32'(wr_oob), 1);
    step(733, 500);
    @(negedge clk);
    chk("oob_sticky2", 32'(wr_oob), 1);
    step(740, 500);
    wr_req = 1'b1;
    wr_addr = 15'd50;
    wr_data = 8'h33;
    rst = 1'b1;
    step(741, 500);
    wr_req = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    step(742, 500);
    rst = 1'b0;
    step(743, 500);
    @(negedge clk);
    chk("midrst_no_ack", 32'(wr_ack), 0);
    chk("midrst_no_we", 32'(mem_we), 0);
    for (int h = 0; h < 660; h++) begin
      step(h, 0);
      if (h == 404) begin
        @(negedge clk);
        chk("readback_100", 32'(pix_data), 32'(shadow[100]));
      end
    end
    for (int h = 0; h < 660; h++) begin
      step(h, 4);
      if (h == 164) begin
        @(negedge clk);
        chk("readback_200", 32'(pix_data), 32'(shadow[200]));
      end
    end
    t0 = ticks;
    for (int f = 0; f < 2; f++) begin
      for (int h = 796; h < 800; h++) step(h, 479);
      for (int h = 0; h < 4; h++) step(h, 480);
      for (int h = 0; h < 4; h++) step(h, 481);
    end
    repeat (4) step(700, 500);
    chk("tick_count", 32'(ticks - t0), 2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
